// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between an instruction-fetch requester and a
// load/store requester, with fetch starvation protection and an ack timeout.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 2,
   parameter int TIMEOUT      = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        ls_req,
   input  logic        ls_wr,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   input  logic [2:0]  ls_mode,
   output logic [31:0] ls_rdata,
   output logic        ls_valid,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_mode,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        bus_err,
   output logic        stall
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;

   localparam logic [2:0] MODE_NONE = 3'b111;
   localparam logic [2:0] MODE_WORD = 3'b010;

   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
   localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

   logic [1:0]  state_q,     state_d;
   logic        mem_req_q,   mem_req_d;
   logic        mem_wr_q,    mem_wr_d;
   logic [31:0] mem_addr_q,  mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [2:0]  mem_mode_q,  mem_mode_d;
   logic [31:0] if_rdata_q,  if_rdata_d;
   logic [31:0] ls_rdata_q,  ls_rdata_d;
   logic        if_valid_q,  if_valid_d;
   logic        ls_valid_q,  ls_valid_d;
   logic        bus_err_q,   bus_err_d;
   logic [7:0]  starve_q,    starve_d;
   logic [7:0]  timer_q,     timer_d;

   logic idle_free;
   logic grant_ls;
   logic grant_if;

   // No grant while a completion pulse is out: the finishing requester's req is stale
   // that cycle, and arbitrating against it would let the other side jump the queue.
   always_comb begin
      idle_free = (state_q == S_IDLE) && !if_valid_q && !ls_valid_q;
      grant_ls  = idle_free && ls_req && (!if_req || (starve_q < STARVE_MAX));
      grant_if  = idle_free && !grant_ls && if_req;
   end

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_wr_d    = mem_wr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_mode_d  = mem_mode_q;
      if_rdata_d  = if_rdata_q;
      ls_rdata_d  = ls_rdata_q;
      if_valid_d  = 1'b0;
      ls_valid_d  = 1'b0;
      bus_err_d   = 1'b0;
      starve_d    = starve_q;
      timer_d     = timer_q;

      case (state_q)
         S_IDLE: begin
            if (grant_ls) begin
               state_d     = S_DATA;
               mem_req_d   = 1'b1;
               mem_wr_d    = ls_wr;
               mem_addr_d  = ls_addr;
               mem_wdata_d = ls_wdata;
               mem_mode_d  = ls_mode;
               timer_d     = 8'd0;
               starve_d    = if_req ? (starve_q + 8'd1) : 8'd0;
            end else if (grant_if) begin
               state_d     = S_FETCH;
               mem_req_d   = 1'b1;
               mem_wr_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = 32'd0;
               mem_mode_d  = MODE_WORD;
               timer_d     = 8'd0;
               starve_d    = 8'd0;
            end
         end
         S_FETCH, S_DATA: begin
            // An ack on the timeout cycle still counts as a normal completion.
            if (mem_ack) begin
               state_d   = S_IDLE;
               mem_req_d = 1'b0;
               if (state_q == S_FETCH) begin
                  if_valid_d = 1'b1;
                  if_rdata_d = mem_rdata;
               end else begin
                  ls_valid_d = 1'b1;
                  if (!mem_wr_q) ls_rdata_d = mem_rdata;
               end
            end else if (timer_q == TMO_LAST) begin
               state_d   = S_IDLE;
               mem_req_d = 1'b0;
               bus_err_d = 1'b1;
               if (state_q == S_FETCH) begin
                  if_valid_d = 1'b1;
                  if_rdata_d = 32'd0;
               end else begin
                  ls_valid_d = 1'b1;
                  ls_rdata_d = 32'd0;
               end
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         default: begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mem_req_q   <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         mem_mode_q  <= MODE_NONE;
         if_rdata_q  <= 32'd0;
         ls_rdata_q  <= 32'd0;
         if_valid_q  <= 1'b0;
         ls_valid_q  <= 1'b0;
         bus_err_q   <= 1'b0;
         starve_q    <= 8'd0;
         timer_q     <= 8'd0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_mode_q  <= mem_mode_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
         if_valid_q  <= if_valid_d;
         ls_valid_q  <= ls_valid_d;
         bus_err_q   <= bus_err_d;
         starve_q    <= starve_d;
         timer_q     <= timer_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_mode  = mem_mode_q;
   assign if_rdata  = if_rdata_q;
   assign ls_rdata  = ls_rdata_q;
   assign if_valid  = if_valid_q;
   assign ls_valid  = ls_valid_q;
   assign bus_err   = bus_err_q;
   assign stall     = (if_req & ~if_valid_q) | (ls_req & ~ls_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int STARVE = 2;
   localparam int TMO    = 4;
   localparam logic T = 1'b1;
   localparam logic F = 1'b0;
   localparam logic [31:0] Z = 32'h0;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        ls_req;
   logic        ls_wr;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic [2:0]  ls_mode;
   logic [31:0] ls_rdata;
   logic        ls_valid;
   logic        mem_req;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_mode;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        bus_err;
   logic        stall;

   mem_port_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_valid  (if_valid),
      .ls_req    (ls_req),
      .ls_wr     (ls_wr),
      .ls_addr   (ls_addr),
      .ls_wdata  (ls_wdata),
      .ls_mode   (ls_mode),
      .ls_rdata  (ls_rdata),
      .ls_valid  (ls_valid),
      .mem_req   (mem_req),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_mode  (mem_mode),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .bus_err   (bus_err),
      .stall     (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b", nm, act, exp);
      end
   endtask

   task automatic chk3(input string nm, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b", nm, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed vectors: inputs for one cycle, stall expected before the edge,
   // registered outputs expected after it.
   typedef struct {
      logic        rst;
      logic        ifr;
      logic [31:0] ifa;
      logic        lsr;
      logic        lsw;
      logic [31:0] lsa;
      logic [31:0] lsd;
      logic [2:0]  lsm;
      logic        ack;
      logic [31:0] rd;
      logic        e_stall;
      logic        e_req;
      logic        e_wr;
      logic [31:0] e_addr;
      logic [2:0]  e_mode;
      logic        e_ifv;
      logic        e_lsv;
      logic        e_err;
      logic [31:0] e_ifrd;
      logic [31:0] e_lsrd;
   } vec_t;

   vec_t vec [13];

   // Reference model: one outstanding transaction record plus requester-level state.
   typedef struct {
      logic        act;
      logic        fetch;
      int          waited;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        wr;
      logic [2:0]  mode;
   } txn_t;

   txn_t        cur;
   int          m_streak;
   logic        m_ifv, m_lsv, m_err;
   logic [31:0] m_ifrd, m_lsrd;

   function automatic void model_reset();
      cur      = '{F, F, 0, Z, Z, F, 3'b111};
      m_streak = 0;
      m_ifv    = F;
      m_lsv    = F;
      m_err    = F;
      m_ifrd   = Z;
      m_lsrd   = Z;
   endfunction

   function automatic void model_step();
      logic pifv, plsv;
      if (rst) begin
         model_reset();
         return;
      end
      pifv  = m_ifv;
      plsv  = m_lsv;
      m_ifv = F;
      m_lsv = F;
      m_err = F;
      if (cur.act) begin
         if (mem_ack || (cur.waited + 1 >= TMO)) begin
            cur.act = F;
            m_err   = !mem_ack;
            if (cur.fetch) begin
               m_ifv  = T;
               m_ifrd = mem_ack ? mem_rdata : Z;
            end else begin
               m_lsv = T;
               if (!mem_ack) m_lsrd = Z;
               else if (!cur.wr) m_lsrd = mem_rdata;
            end
         end else begin
            cur.waited++;
         end
      end else if (!pifv && !plsv) begin
         if (ls_req && (!if_req || m_streak < STARVE)) begin
            cur      = '{T, F, 0, ls_addr, ls_wdata, ls_wr, ls_mode};
            m_streak = if_req ? m_streak + 1 : 0;
         end else if (if_req) begin
            cur      = '{T, T, 0, if_addr, Z, F, 3'b010};
            m_streak = 0;
         end
      end
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit   grants[$];
      bit   exp_order[4];
      logic prev_req;

      rst = F; if_req = F; if_addr = Z; ls_req = F; ls_wr = F;
      ls_addr = Z; ls_wdata = Z; ls_mode = 3'b111; mem_ack = F; mem_rdata = Z;

      vec[0]  = '{T,F,Z,F,F,Z,Z,3'd7,F,Z,                          F,F,F,Z,3'd7,F,F,F,Z,Z};
      vec[1]  = '{F,F,Z,F,F,Z,Z,3'd7,F,Z,                          F,F,F,Z,3'd7,F,F,F,Z,Z};
      vec[2]  = '{F,T,32'h100,F,F,Z,Z,3'd7,F,Z,                    T,T,F,32'h100,3'd2,F,F,F,Z,Z};
      vec[3]  = '{F,T,32'h100,F,F,Z,Z,3'd7,T,32'h13,               T,F,F,32'h100,3'd2,T,F,F,32'h13,Z};
      vec[4]  = '{F,T,32'h100,F,F,Z,Z,3'd7,F,Z,                    F,F,F,32'h100,3'd2,F,F,F,32'h13,Z};
      vec[5]  = '{F,F,Z,F,F,Z,Z,3'd7,F,Z,                          F,F,F,32'h100,3'd2,F,F,F,32'h13,Z};
      vec[6]  = '{F,T,32'h104,T,F,32'h2000,Z,3'd2,F,Z,             T,T,F,32'h2000,3'd2,F,F,F,32'h13,Z};
      vec[7]  = '{F,T,32'h104,T,F,32'h2000,Z,3'd2,T,32'hCAFE0001,  T,F,F,32'h2000,3'd2,F,T,F,32'h13,32'hCAFE0001};
      vec[8]  = '{F,T,32'h104,T,F,32'h2000,Z,3'd2,F,Z,             T,F,F,32'h2000,3'd2,F,F,F,32'h13,32'hCAFE0001};
      vec[9]  = '{F,T,32'h104,F,F,Z,Z,3'd7,F,Z,                    T,T,F,32'h104,3'd2,F,F,F,32'h13,32'hCAFE0001};
      vec[10] = '{F,T,32'h104,F,F,Z,Z,3'd7,T,32'h00500093,         T,F,F,32'h104,3'd2,T,F,F,32'h00500093,32'hCAFE0001};
      vec[11] = '{F,T,32'h104,F,F,Z,Z,3'd7,T,32'hFFFFFFFF,         F,F,F,32'h104,3'd2,F,F,F,32'h00500093,32'hCAFE0001};
      vec[12] = '{F,F,Z,F,F,Z,Z,3'd7,T,32'h00005555,               F,F,F,32'h104,3'd2,F,F,F,32'h00500093,32'hCAFE0001};

      for (int i = 0; i < 13; i++) begin
         rst = vec[i].rst; if_req = vec[i].ifr; if_addr = vec[i].ifa;
         ls_req = vec[i].lsr; ls_wr = vec[i].lsw; ls_addr = vec[i].lsa;
         ls_wdata = vec[i].lsd; ls_mode = vec[i].lsm;
         mem_ack = vec[i].ack; mem_rdata = vec[i].rd;
         #1;
         chk1($sformatf("v%0d_stall", i), stall, vec[i].e_stall);
         tick();
         chk1($sformatf("v%0d_mem_req", i), mem_req, vec[i].e_req);
         chk1($sformatf("v%0d_mem_wr", i), mem_wr, vec[i].e_wr);
         chk32($sformatf("v%0d_mem_addr", i), mem_addr, vec[i].e_addr);
         chk3($sformatf("v%0d_mem_mode", i), mem_mode, vec[i].e_mode);
         chk1($sformatf("v%0d_if_valid", i), if_valid, vec[i].e_ifv);
         chk1($sformatf("v%0d_ls_valid", i), ls_valid, vec[i].e_lsv);
         chk1($sformatf("v%0d_bus_err", i), bus_err, vec[i].e_err);
         chk32($sformatf("v%0d_if_rdata", i), if_rdata, vec[i].e_ifrd);
         chk32($sformatf("v%0d_ls_rdata", i), ls_rdata, vec[i].e_lsrd);
      end

      // Starvation: fetch held, loads re-issued back-to-back, zero-wait memory.
      rst = T; if_req = F; ls_req = F; mem_ack = F;
      tick();
      rst = F; if_req = T; if_addr = 32'h300;
      ls_req = T; ls_wr = F; ls_addr = 32'h4000; ls_mode = 3'b010;
      prev_req = F;
      exp_order = '{1'b0, 1'b0, 1'b1, 1'b0};
      for (int c = 0; c < 16; c++) begin
         mem_ack = mem_req;
         mem_rdata = $urandom;
         tick();
         if (mem_req && !prev_req) grants.push_back(mem_addr == 32'h300);
         prev_req = mem_req;
         if (ls_valid) ls_addr = ls_addr + 32'd4;
      end
      chk32("starve_ngrants", (grants.size() >= 4) ? 32'd4 : 32'(grants.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < grants.size()) chk1($sformatf("starve_grant%0d_is_fetch", i), grants[i], exp_order[i]);

      // Store with ack on the 4th waiting cycle, which is also the timeout cycle.
      rst = T; if_req = F; ls_req = F; mem_ack = F;
      tick();
      rst = F;
      ls_req = T; ls_wr = F; ls_addr = 32'h5000; ls_wdata = Z; ls_mode = 3'b010;
      tick();
      mem_ack = T; mem_rdata = 32'h11223344;
      tick();
      chk32("seed_ls_rdata", ls_rdata, 32'h11223344);
      mem_ack = F; ls_wr = T; ls_addr = 32'h5004; ls_wdata = 32'hDEADBEEF;
      tick();
      chk1("st_turnaround_req", mem_req, F);
      tick();
      for (int w = 1; w <= 4; w++) begin
         mem_ack = (w == 4); mem_rdata = 32'h99999999;
         chk1($sformatf("st_w%0d_req", w), mem_req, T);
         chk1($sformatf("st_w%0d_wr", w), mem_wr, T);
         chk32($sformatf("st_w%0d_addr", w), mem_addr, 32'h5004);
         chk32($sformatf("st_w%0d_wdata", w), mem_wdata, 32'hDEADBEEF);
         chk3($sformatf("st_w%0d_mode", w), mem_mode, 3'b010);
         chk1($sformatf("st_w%0d_ls_valid", w), ls_valid, F);
         tick();
      end
      chk1("st_done_ls_valid", ls_valid, T);
      chk1("st_done_bus_err", bus_err, F);
      chk1("st_done_mem_req", mem_req, F);
      chk32("st_done_ls_rdata", ls_rdata, 32'h11223344);
      ls_req = F; mem_ack = F;
      tick();
      chk1("st_after_ls_valid", ls_valid, F);

      // Load timeout with no ack.
      ls_req = T; ls_wr = F; ls_addr = 32'h6000; ls_mode = 3'b010;
      tick();
      for (int w = 1; w <= 4; w++) begin
         chk1($sformatf("to_w%0d_req", w), mem_req, T);
         chk1($sformatf("to_w%0d_bus_err", w), bus_err, F);
         chk1($sformatf("to_w%0d_ls_valid", w), ls_valid, F);
         tick();
      end
      chk1("to_mem_req", mem_req, F);
      chk1("to_bus_err", bus_err, T);
      chk1("to_ls_valid", ls_valid, T);
      chk32("to_ls_rdata", ls_rdata, Z);
      ls_req = F;
      tick();
      chk1("to_after_bus_err", bus_err, F);
      chk1("to_after_ls_valid", ls_valid, F);

      // Reset in the middle of a data wait, ack arrives just after reset.
      ls_req = T; ls_addr = 32'h7000;
      tick();
      chk1("rm_granted", mem_req, T);
      tick();
      rst = T; ls_req = F;
      tick();
      chk1("rm_rst_mem_req", mem_req, F);
      chk3("rm_rst_mem_mode", mem_mode, 3'b111);
      rst = F; mem_ack = T; mem_rdata = 32'h77;
      tick();
      chk1("rm_ls_valid", ls_valid, F);
      chk1("rm_mem_req", mem_req, F);
      chk3("rm_mem_mode", mem_mode, 3'b111);
      chk32("rm_ls_rdata", ls_rdata, Z);
      chk1("rm_bus_err", bus_err, F);
      mem_ack = F; if_req = T; if_addr = 32'h900;
      tick();
      chk1("rm_next_req", mem_req, T);
      chk32("rm_next_addr", mem_addr, 32'h900);
      mem_ack = T; mem_rdata = 32'h1234;
      tick();
      chk1("rm_next_if_valid", if_valid, T);
      chk32("rm_next_if_rdata", if_rdata, 32'h1234);
      if_req = F; mem_ack = F;
      tick();

      // Randomized traffic against the reference model.
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         if (if_req && if_valid) begin
            if ($urandom_range(0, 1) == 1) if_addr = $urandom;
            else if_req = F;
         end else if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = T; if_addr = $urandom;
         end
         if (ls_req && ls_valid) begin
            if ($urandom_range(0, 1) == 1) begin
               ls_wr = 1'($urandom_range(0, 1)); ls_addr = $urandom;
               ls_wdata = $urandom; ls_mode = 3'($urandom_range(0, 7));
            end else ls_req = F;
         end else if (!ls_req && $urandom_range(0, 2) == 0) begin
            ls_req = T; ls_wr = 1'($urandom_range(0, 1)); ls_addr = $urandom;
            ls_wdata = $urandom; ls_mode = 3'($urandom_range(0, 7));
         end
         mem_ack   = ($urandom_range(0, 2) == 0);
         mem_rdata = $urandom;
         rst       = (c == 0) || ($urandom_range(0, 149) == 0);
         #1;
         if (c != 0) chk1($sformatf("r%0d_stall", c), stall, (if_req & ~m_ifv) | (ls_req & ~m_lsv));
         model_step();
         tick();
         chk1($sformatf("r%0d_mem_req", c), mem_req, cur.act);
         chk32($sformatf("r%0d_mem_addr", c), mem_addr, cur.addr);
         chk1($sformatf("r%0d_mem_wr", c), mem_wr, cur.wr);
         chk32($sformatf("r%0d_mem_wdata", c), mem_wdata, cur.wdata);
         chk3($sformatf("r%0d_mem_mode", c), mem_mode, cur.mode);
         chk1($sformatf("r%0d_if_valid", c), if_valid, m_ifv);
         chk1($sformatf("r%0d_ls_valid", c), ls_valid, m_lsv);
         chk1($sformatf("r%0d_bus_err", c), bus_err, m_err);
         chk32($sformatf("r%0d_if_rdata", c), if_rdata, m_ifrd);
         chk32($sformatf("r%0d_ls_rdata", c), ls_rdata, m_lsrd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
